// File: rtl/button_ctrl_if.sv
// Front-panel bus: raw buttons and enable in, debounced levels, events and settings out.
interface button_ctrl_if #(
    parameter int unsigned VAL_W = 8
);
    logic [2:0]       btn_raw;
    logic             en;
    logic [2:0]       btn_state;
    logic [2:0]       evt_press;
    logic [VAL_W-1:0] value;
    logic [1:0]       mode;
    logic             upd;
    logic             sat;

    modport master (
        output btn_raw, en,
        input  btn_state, evt_press, value, mode, upd, sat
    );

    modport slave (
        input  btn_raw, en,
        output btn_state, evt_press, value, mode, upd, sat
    );
endinterface

// File: rtl/button_ctrl.sv
// Front-panel button controller: debounce of up/down/mode, press / long-press /
// auto-repeat sequencing, and the runtime value/mode settings register.
module button_ctrl #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DEB_TICKS  = 5,
    parameter int unsigned LONG_TICKS = 500,
    parameter int unsigned REP_TICKS  = 100,
    parameter int unsigned VAL_W      = 8,
    parameter int unsigned VAL_DEF    = 128,
    parameter int unsigned VAL_MAX    = 255,
    parameter int unsigned N_MODE     = 4
) (
    input logic          clk,
    input logic          rst_n,
    button_ctrl_if.slave bus
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
    localparam int unsigned HMAX   = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
    localparam int unsigned HCNT_W = $clog2(HMAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
    localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_TICKS - 1);
    localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REP_TICKS - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [VAL_W:0]    EXT_ONE   = (VAL_W + 1)'(1);
    localparam logic [VAL_W:0]    EXT_MAX   = (VAL_W + 1)'(VAL_MAX);
    localparam logic [1:0]        MODE_LAST = 2'(N_MODE - 1);

    typedef enum logic [1:0] {StIdle, StPressed, StRepeat} hold_st_e;
    typedef enum logic [1:0] {MdIdle, MdHeld, MdLong} mode_st_e;

    logic [2:0]        sync1_q, sync2_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic [DEB_W-1:0]  deb_cnt_q [3];
    logic [2:0]        btn_state_q, evt_press_q;

    hold_st_e          hold_q, hold_d;
    logic              own_dn_q, own_dn_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              owner_held;
    logic              step_up, step_dn;

    mode_st_e          mst_q, mst_d;
    logic [HCNT_W-1:0] mcnt_q, mcnt_d;
    logic              mode_adv, restore;

    logic [VAL_W-1:0]  value_q, value_d;
    logic [1:0]        mode_q, mode_d;
    logic              upd_q, upd_d;
    logic              sat_q, sat_d;
    logic [VAL_W:0]    step_ext;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign owner_held = own_dn_q ? btn_state_q[1] : btn_state_q[0];

    // Two-stage synchroniser for the asynchronous raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Shared sample-tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Per-button debounce; evt_press rises together with the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
            btn_state_q <= '0;
            evt_press_q <= '0;
        end else begin
            evt_press_q <= '0;
            if (tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2_q[i] != btn_state_q[i]) begin
                        if (deb_cnt_q[i] == DEB_LAST) begin
                            btn_state_q[i] <= sync2_q[i];
                            evt_press_q[i] <= sync2_q[i];
                            deb_cnt_q[i]   <= '0;
                        end else begin
                            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    // Up/down hold sequencer: first pressed button owns stepping until released.
    always_comb begin
        hold_d   = hold_q;
        own_dn_d = own_dn_q;
        hcnt_d   = hcnt_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        if (!bus.en) begin
            hold_d   = StIdle;
            own_dn_d = 1'b0;
            hcnt_d   = '0;
        end else begin
            unique case (hold_q)
                StIdle: begin
                    hcnt_d = '0;
                    // Up is tested first so it wins a same-cycle press.
                    if (evt_press_q[0]) begin
                        own_dn_d = 1'b0;
                        step_up  = 1'b1;
                        hold_d   = StPressed;
                    end else if (evt_press_q[1]) begin
                        own_dn_d = 1'b1;
                        step_dn  = 1'b1;
                        hold_d   = StPressed;
                    end
                end
                StPressed: begin
                    if (!owner_held) begin
                        hold_d = StIdle;
                        hcnt_d = '0;
                    end else if (tick) begin
                        if (hcnt_q == LONG_LAST) begin
                            step_up = !own_dn_q;
                            step_dn = own_dn_q;
                            hold_d  = StRepeat;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d = hcnt_q + HCNT_ONE;
                        end
                    end
                end
                StRepeat: begin
                    if (!owner_held) begin
                        hold_d = StIdle;
                        hcnt_d = '0;
                    end else if (tick) begin
                        if (hcnt_q == REP_LAST) begin
                            step_up = !own_dn_q;
                            step_dn = own_dn_q;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d = hcnt_q + HCNT_ONE;
                        end
                    end
                end
                default: begin
                    hold_d = StIdle;
                    hcnt_d = '0;
                end
            endcase
        end
    end

    // Hold sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= StIdle;
            own_dn_q <= 1'b0;
            hcnt_q   <= '0;
        end else begin
            hold_q   <= hold_d;
            own_dn_q <= own_dn_d;
            hcnt_q   <= hcnt_d;
        end
    end

    // Mode button: short press advances on release, long press restores the value.
    always_comb begin
        mst_d    = mst_q;
        mcnt_d   = mcnt_q;
        mode_adv = 1'b0;
        restore  = 1'b0;
        if (!bus.en) begin
            mst_d  = MdIdle;
            mcnt_d = '0;
        end else begin
            unique case (mst_q)
                MdIdle: begin
                    mcnt_d = '0;
                    if (evt_press_q[2]) begin
                        mst_d = MdHeld;
                    end
                end
                MdHeld: begin
                    if (!btn_state_q[2]) begin
                        mode_adv = 1'b1;
                        mst_d    = MdIdle;
                    end else if (tick) begin
                        if (mcnt_q == LONG_LAST) begin
                            restore = 1'b1;
                            mst_d   = MdLong;
                        end else begin
                            mcnt_d = mcnt_q + HCNT_ONE;
                        end
                    end
                end
                MdLong: begin
                    // Release after a restore does not advance the mode.
                    if (!btn_state_q[2]) begin
                        mst_d = MdIdle;
                    end
                end
                default: begin
                    mst_d = MdIdle;
                end
            endcase
        end
    end

    // Mode sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_q  <= MdIdle;
            mcnt_q <= '0;
        end else begin
            mst_q  <= mst_d;
            mcnt_q <= mcnt_d;
        end
    end

    // Settings update: restore beats a step; a step past a limit only flags sat.
    always_comb begin
        value_d  = value_q;
        mode_d   = mode_q;
        sat_d    = 1'b0;
        step_ext = step_dn ? ({1'b0, value_q} - EXT_ONE) : ({1'b0, value_q} + EXT_ONE);
        if (restore) begin
            value_d = VAL_W'(VAL_DEF);
        end else if (step_up || step_dn) begin
            // Down from 0 wraps the extended result high, so one compare covers both ends.
            if (step_ext > EXT_MAX) begin
                sat_d = 1'b1;
            end else begin
                value_d = step_ext[VAL_W-1:0];
            end
        end
        if (mode_adv) begin
            mode_d = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
        end
        upd_d = (value_d != value_q) || (mode_d != mode_q);
    end

    // Settings register and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= VAL_W'(VAL_DEF);
            mode_q  <= 2'd0;
            upd_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            mode_q  <= mode_d;
            upd_q   <= upd_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.btn_state = btn_state_q;
    assign bus.evt_press = evt_press_q;
    assign bus.value     = value_q;
    assign bus.mode      = mode_q;
    assign bus.upd       = upd_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with a short tick and small value range.
module tb_button_ctrl;

    logic clk;
    logic rst_n;

    int n_total = 0;
    int n_bad   = 0;
    int pe_cnt;
    int upd_cnt = 0;
    int sat_cnt = 0;
    int ev_cnt [3] = '{0, 0, 0};

    button_ctrl_if #(.VAL_W(8)) bus ();

    button_ctrl #(
        .TICK_DIV   (4),
        .DEB_TICKS  (3),
        .LONG_TICKS (8),
        .REP_TICKS  (2),
        .VAL_W      (8),
        .VAL_DEF    (5),
        .VAL_MAX    (10),
        .N_MODE     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; ticks land on edges where this is a multiple of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_cnt <= 0;
        else        pe_cnt <= pe_cnt + 1;
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.upd) upd_cnt++;
        if (bus.sat) sat_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (bus.evt_press[i]) ev_cnt[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_level(input int idx, input logic lvl, input string tag, output int t);
        bit done;
        done = 1'b0;
        t    = -1;
        for (int k = 0; k < 200 && !done; k++) begin
            tick_n(1);
            if (bus.btn_state[idx] == lvl) begin
                done = 1'b1;
                t    = pe_cnt;
            end
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(2);
    endtask

    task automatic press_release(input int idx);
        int t;
        bus.btn_raw[idx] = 1'b1;
        wait_level(idx, 1'b1, "pr_rise", t);
        bus.btn_raw[idx] = 1'b0;
        wait_level(idx, 1'b0, "pr_fall", t);
        tick_n(2);
    endtask

    initial begin
        int t, n_last, first_t, u0, s0, e0, e1;
        bus.btn_raw = 3'b000;
        bus.en      = 1'b1;
        rst_n       = 1'b0;
        tick_n(2);
        check("rst_value", int'(bus.value), 5);
        check("rst_mode", int'(bus.mode), 0);
        check("rst_state", int'(bus.btn_state), 0);
        check("rst_evt", int'(bus.evt_press), 0);
        check("rst_upd_sat", int'({bus.upd, bus.sat}), 0);
        rst_n = 1'b1;
        tick_n(4);

        // Bounce on up, then steady high.
        u0 = upd_cnt; e0 = ev_cnt[0]; n_last = 0;
        for (int k = 0; k < 9; k++) begin
            bus.btn_raw[0] = (k % 2 == 0);
            if (k == 8) n_last = pe_cnt;
            tick_n(5);
        end
        wait_level(0, 1'b1, "bounce_rise", t);
        first_t = n_last + 3;
        while (first_t % 4 != 0) first_t++;
        check("bounce_latency", t, first_t + 8);
        tick_n(3);
        check("bounce_evt", ev_cnt[0] - e0, 1);
        check("bounce_value", int'(bus.value), 6);
        check("bounce_upd", upd_cnt - u0, 1);
        bus.btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, "bounce_fall", t);
        tick_n(2);

        // Long hold up from 5: press, long step, repeats, clamp at 10.
        do_reset();
        u0 = upd_cnt; s0 = sat_cnt;
        bus.btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, "long_rise", t);
        tick_n(30);
        check("long_before", int'(bus.value), 6);
        tick_n(4);
        check("long_step", int'(bus.value), 7);
        tick_n(50);
        check("long_clamp", int'(bus.value), 10);
        check("long_sat", sat_cnt - s0, 3);
        check("long_upd", upd_cnt - u0, 5);
        bus.btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, "long_fall", t);
        tick_n(2);

        // Down from 5 to the lower clamp.
        do_reset();
        u0 = upd_cnt; s0 = sat_cnt;
        bus.btn_raw[1] = 1'b1;
        wait_level(1, 1'b1, "down_rise", t);
        tick_n(76);
        check("down_value", int'(bus.value), 0);
        check("down_sat", sat_cnt - s0, 2);
        check("down_upd", upd_cnt - u0, 5);
        bus.btn_raw[1] = 1'b0;
        wait_level(1, 1'b0, "down_fall", t);
        tick_n(2);

        // Short mode presses with wrap.
        do_reset();
        u0 = upd_cnt;
        press_release(2);
        check("mode_1", int'(bus.mode), 1);
        press_release(2);
        check("mode_2", int'(bus.mode), 2);
        press_release(2);
        check("mode_wrap", int'(bus.mode), 0);
        check("mode_upd", upd_cnt - u0, 3);
        press_release(2);
        check("mode_again", int'(bus.mode), 1);

        // Raise value to 9, then long mode press restores 5.
        for (int k = 0; k < 4; k++) press_release(0);
        check("pre_restore", int'(bus.value), 9);
        u0 = upd_cnt;
        bus.btn_raw[2] = 1'b1;
        wait_level(2, 1'b1, "restore_rise", t);
        tick_n(30);
        check("restore_before", int'(bus.value), 9);
        tick_n(4);
        check("restore_value", int'(bus.value), 5);
        check("restore_mode", int'(bus.mode), 1);
        check("restore_upd", upd_cnt - u0, 1);
        bus.btn_raw[2] = 1'b0;
        wait_level(2, 1'b0, "restore_fall", t);
        tick_n(3);
        check("restore_no_adv", int'(bus.mode), 1);
        check("restore_upd_end", upd_cnt - u0, 1);

        // Same-cycle up+down: up wins; down ignored until re-pressed.
        do_reset();
        u0 = upd_cnt; e0 = ev_cnt[0]; e1 = ev_cnt[1];
        bus.btn_raw = 3'b011;
        wait_level(0, 1'b1, "both_rise", t);
        tick_n(2);
        check("both_evt_up", ev_cnt[0] - e0, 1);
        check("both_evt_dn", ev_cnt[1] - e1, 1);
        check("both_value", int'(bus.value), 6);
        bus.btn_raw = 3'b010;
        wait_level(0, 1'b0, "both_up_fall", t);
        tick_n(60);
        check("down_ignored", int'(bus.value), 6);
        check("both_upd", upd_cnt - u0, 1);
        bus.btn_raw = 3'b000;
        wait_level(1, 1'b0, "both_dn_fall", t);
        tick_n(2);
        press_release(1);
        check("down_repress", int'(bus.value), 5);

        // en low: debounce runs, settings frozen; held button needs a new press.
        u0 = upd_cnt; s0 = sat_cnt; e0 = ev_cnt[0];
        bus.en = 1'b0;
        bus.btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, "en_rise", t);
        tick_n(2);
        check("en_evt", ev_cnt[0] - e0, 1);
        check("en_value", int'(bus.value), 5);
        bus.en = 1'b1;
        tick_n(40);
        check("en_held_value", int'(bus.value), 5);
        check("en_upd", upd_cnt - u0, 0);
        check("en_sat", sat_cnt - s0, 0);
        bus.btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, "en_fall", t);
        tick_n(2);
        press_release(0);
        check("en_repress", int'(bus.value), 6);

        // Reset asserted mid-repeat.
        do_reset();
        press_release(2);
        check("rr_mode", int'(bus.mode), 1);
        bus.btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, "rr_rise", t);
        tick_n(44);
        check("rr_value", int'(bus.value), 8);
        rst_n = 1'b0;
        #1;
        check("rr_rst_value", int'(bus.value), 5);
        check("rr_rst_mode", int'(bus.mode), 0);
        check("rr_rst_state", int'(bus.btn_state), 0);
        check("rr_rst_strobes", int'({bus.evt_press, bus.upd, bus.sat}), 0);
        bus.btn_raw = 3'b000;
        tick_n(3);
        u0 = upd_cnt; s0 = sat_cnt;
        rst_n = 1'b1;
        tick_n(20);
        check("rr_post_upd", upd_cnt - u0, 0);
        check("rr_post_sat", sat_cnt - s0, 0);
        check("rr_post_value", int'(bus.value), 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
- Front-panel controller for the ANC board. It debounces three pushbuttons (up, down, mode) with one shared sample-tick prescaler and per-button counters.
- It sequences press, long-press and auto-repeat events, and owns the runtime settings register: an 8-bit step value (e.g. ANC gain) and a mode index.
- Downstream blocks consume `value`, `mode` and the one-cycle `upd` strobe.

Parameters:
- TICK_DIV, 100000: clk cycles per sample tick (1 ms at 100 MHz).
- DEB_TICKS, 5: consecutive disagreeing ticks before a debounced state flips.
- LONG_TICKS, 500: ticks held before a long-press action.
- REP_TICKS, 100: ticks between auto-repeat steps after a long press.
- VAL_W, 8: width of `value`.
- VAL_DEF, 128: reset/restore value of `value`.
- VAL_MAX, 255: upper clamp of `value`; must satisfy VAL_DEF <= VAL_MAX < 2^VAL_W.
- N_MODE, 4: number of modes, range 2..4.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- btn_raw, in, 3: raw asynchronous buttons, active-high; [0]=up, [1]=down, [2]=mode.
- en, in, 1: when low, settings frozen and hold FSMs held IDLE.
- btn_state, out, 3: debounced button levels.
- evt_press, out, 3: one-cycle pulse per debounced rising edge.
- value, out, VAL_W: current setting.
- mode, out, 2: current mode, 0..N_MODE-1.
- upd, out, 1: one-cycle pulse in the cycle after `value` or `mode` changes.
- sat, out, 1: one-cycle pulse when a step is requested at a clamp limit.

Behaviour:
- Reset (async assert, sync release): sync FFs, btn_state, evt_press, counters, upd and sat = 0; value = VAL_DEF; mode = 0; all FSMs IDLE.
- Synchroniser: 2-FF per button.
- Tick: counter 0..TICK_DIV-1; `tick` is high for one cycle at wrap.
- Debounce, per button, evaluated only on tick:
  - if sync != btn_state, cnt++; else cnt = 0;
  - when cnt reaches DEB_TICKS-1 and sync still differs, btn_state <= sync and cnt = 0.
  - Latency from raw edge: 2 clk + DEB_TICKS ticks.
- evt_press[i] is high in the same cycle btn_state[i] first reads 1.
- Up/down ownership: the first of up/down to press owns stepping; the other is ignored until the owner releases. On a same-cycle press, up wins.
- Hold FSM (owner only):
  - IDLE: on press, apply one step -> PRESSED, hcnt = 0.
  - PRESSED: hcnt++ per tick; at LONG_TICKS, apply step -> REPEAT, hcnt = 0.
  - REPEAT: hcnt++ per tick; at REP_TICKS, apply step, hcnt = 0.
  - Any state: on release -> IDLE.
- Step: up = value+1, down = value-1, evaluated at VAL_W+1 bits.
  - If the result falls outside 0..VAL_MAX: value unchanged, sat pulses, no upd.
- Mode button:
  - short press (release before LONG_TICKS): mode = (mode+1) mod N_MODE on release, wrapping N_MODE-1 -> 0.
  - reaching LONG_TICKS while held: value = VAL_DEF and mode unchanged; no mode advance on that release.
  - Mode actions are independent of up/down ownership.
- Simultaneous value writes in one cycle: the mode-long restore wins over an up/down step; the step is dropped.
- en low: btn_state and evt_press still operate; value and mode held; FSMs forced IDLE; no upd or sat. A button held while en rises is treated as a new press only after release.
- upd fires exactly once per cycle in which value or mode changes, in the following cycle. It never fires for a no-op (e.g. restore when value already equals VAL_DEF).
- Reset mid-hold: everything returns to reset values; no pulse is emitted on release of rst_n.

Test Plan (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8, REP_TICKS=2, VAL_MAX=10, VAL_DEF=5, N_MODE=3):
- Bounce: up toggles every 5 clk for 40 clk, then held steady -> btn_state[0] rises exactly 2 clk + 3 ticks after the last edge; evt_press[0] pulses once; value=6; one upd.
- Long hold up from 5: hold for 8 ticks past debounce -> value=7 at long-press, then +1 every 2 ticks; clamps at 10; sat pulses on each further attempt; upd stops.
- Down at 0 (drive value down from 5) -> value stops at 0; sat pulses; no upd.
- Mode: three short presses -> mode 1, 2, 0 (wrap), 3 upd pulses.
- Mode long press with value=9 -> value=5, mode unchanged, one upd; no mode advance on release.
- Same-cycle up+down press -> value=6 (up wins). Then release up while down held -> no further steps until down is released and re-pressed.
- en=0 while pressing up -> evt_press[0] pulses; value unchanged; no upd.
- rst_n asserted mid-REPEAT -> value=5, mode=0, all outputs 0 immediately (async).
